// File: rtl/pipe_datapath_if.sv
// Issue, memory, writeback and debug signals of pipe_datapath bundled as one interface.
interface pipe_datapath_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned AW = 5
);
    // Issue port
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] sa;
    logic [AW-1:0] sb;
    logic [AW-1:0] da;
    logic          wr;
    logic          sfl;
    logic          m;
    logic [2:0]    fs;
    logic [DW-1:0] k;
    logic          ld;
    logic          st;
    // Memory port
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    // Writeback, flags and debug
    logic          wb_valid;
    logic [AW-1:0] wb_da;
    logic [DW-1:0] wb_data;
    logic [3:0]    stat;
    logic [AW-1:0] dbg_sel;
    logic [DW-1:0] dbg_data;

    // Datapath side
    modport slave (
        input  in_valid, sa, sb, da, wr, sfl, m, fs, k, ld, st, mem_rdata, mem_ack, dbg_sel,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_da, wb_data, stat,
               dbg_data
    );

    // Issuer / memory / observer side
    modport master (
        output in_valid, sa, sb, da, wr, sfl, m, fs, k, ld, st, mem_rdata, mem_ack, dbg_sel,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, wb_valid, wb_da, wb_data, stat,
               dbg_data
    );
endinterface

// File: rtl/pipe_datapath.sv
// Two-stage (execute / writeback) datapath with register file, ALU, flags and a
// blocking load/store controller. The top register index reads as zero.
module pipe_datapath #(
    parameter int unsigned DW   = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input logic            clk,
    input logic            rst,
    pipe_datapath_if.slave bus
);
    localparam int unsigned SHW = $clog2(DW);
    localparam logic [AW-1:0] ZeroReg = AW'(NREG - 1);

    typedef enum logic [0:0] {StIdle, StMem} state_e;

    state_e state_q, state_d;

    logic [DW-1:0] rf_q [NREG];
    logic [DW-1:0] rf_d [NREG];

    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_da_q, wb_da_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic [3:0]    stat_q, stat_d;
    logic [DW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_da_q, mem_da_d;
    logic          mem_wb_q, mem_wb_d;   // pending load will write back

    logic          accept;
    logic          is_mem;
    logic [DW-1:0] op_a, reg_b, op_b, b_eff, alu_res;
    logic [DW:0]   sum_w;
    logic          is_sub, alu_c, alu_v;

    assign accept = bus.in_valid && (state_q == StIdle);
    assign is_mem = bus.ld || bus.st;

    // Operand fetch with W-stage forwarding; the zero register is never forwarded
    always_comb begin
        op_a = rf_q[bus.sa];
        if (bus.sa == ZeroReg) begin
            op_a = '0;
        end else if (wb_valid_q && (wb_da_q == bus.sa)) begin
            op_a = wb_data_q;
        end
        reg_b = rf_q[bus.sb];
        if (bus.sb == ZeroReg) begin
            reg_b = '0;
        end else if (wb_valid_q && (wb_da_q == bus.sb)) begin
            reg_b = wb_data_q;
        end
        op_b = bus.m ? bus.k : reg_b;
    end

    // ALU: SUB shares the adder as A + ~B + 1
    always_comb begin
        is_sub  = (bus.fs == 3'd1);
        b_eff   = is_sub ? ~op_b : op_b;
        sum_w   = {1'b0, op_a} + {1'b0, b_eff} + {{DW{1'b0}}, is_sub};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.fs)
            3'd0, 3'd1: begin
                alu_res = sum_w[DW-1:0];
                alu_c   = sum_w[DW];
                alu_v   = (op_a[DW-1] == b_eff[DW-1]) && (sum_w[DW-1] != op_a[DW-1]);
            end
            3'd2:    alu_res = op_a & op_b;
            3'd3:    alu_res = op_a | op_b;
            3'd4:    alu_res = op_a ^ op_b;
            3'd5:    alu_res = op_b;
            3'd6:    alu_res = op_a << op_b[SHW-1:0];
            3'd7:    alu_res = op_a >> op_b[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next state: LD/ST block issue until the memory acknowledges
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept && is_mem) state_d = StMem;
            StMem:   if (bus.mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Controller outputs; memory bus reads as zero outside an access
    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.mem_req   = (state_q == StMem);
        bus.mem_we    = (state_q == StMem) && mem_we_q;
        bus.mem_addr  = (state_q == StMem) ? mem_addr_q : '0;
        bus.mem_wdata = (state_q == StMem) ? mem_wdata_q : '0;
    end

    // Datapath next state: register file, W stage, flags and memory latches
    always_comb begin
        for (int unsigned i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        wb_valid_d  = 1'b0;
        wb_da_d     = wb_da_q;
        wb_data_d   = wb_data_q;
        stat_d      = stat_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_da_d    = mem_da_q;
        mem_wb_d    = mem_wb_q;

        if (wb_valid_q) begin
            rf_d[wb_da_q] = wb_data_q;
        end

        if (accept) begin
            if (bus.sfl) begin
                stat_d = {alu_res[DW-1], (alu_res == '0), alu_c, alu_v};
            end
            if (is_mem) begin
                mem_addr_d  = alu_res;
                mem_wdata_d = reg_b;
                mem_we_d    = !bus.ld;   // LD wins when both are set
                mem_da_d    = bus.da;
                mem_wb_d    = bus.ld && bus.wr && (bus.da != ZeroReg);
            end else if (bus.wr && (bus.da != ZeroReg)) begin
                wb_valid_d = 1'b1;
                wb_da_d    = bus.da;
                wb_data_d  = alu_res;
            end
        end

        if ((state_q == StMem) && bus.mem_ack && mem_wb_q) begin
            wb_valid_d = 1'b1;
            wb_da_d    = mem_da_q;
            wb_data_d  = bus.mem_rdata;
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            wb_valid_q  <= 1'b0;
            wb_da_q     <= '0;
            wb_data_q   <= '0;
            stat_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_da_q    <= '0;
            mem_wb_q    <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
            wb_valid_q  <= wb_valid_d;
            wb_da_q     <= wb_da_d;
            wb_data_q   <= wb_data_d;
            stat_q      <= stat_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_da_q    <= mem_da_d;
            mem_wb_q    <= mem_wb_d;
        end
    end

    // Writeback, flag and debug outputs
    always_comb begin
        bus.wb_valid = wb_valid_q;
        bus.wb_da    = wb_da_q;
        bus.wb_data  = wb_data_q;
        bus.stat     = stat_q;
        bus.dbg_data = (bus.dbg_sel == ZeroReg) ? '0 : rf_q[bus.dbg_sel];
    end
endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: directed scenarios plus randomized back-to-back ALU
// traffic checked against an architectural (sequential) model.
module tb_pipe_datapath;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_datapath_if #(.DW(64), .AW(5)) bus ();

    pipe_datapath #(.DW(64), .NREG(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural model: registers update as soon as an op is issued.
    logic [63:0] m_rf [32];
    logic [3:0]  m_stat;
    logic        m_wb_valid;
    logic [4:0]  m_wb_da;
    logic [63:0] m_wb_data;

    function automatic logic [63:0] ref_alu(input logic [2:0] fs, input logic [63:0] a,
                                            input logic [63:0] b, output logic [3:0] fl);
        logic [64:0] wide;
        logic [63:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (fs)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[63:0];
                c = wide[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            3'd6: r = a << b[5:0];
            default: r = a >> b[5:0];
        endcase
        fl = {r[63], (r == 64'd0), c, v};
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
        m_stat     = 4'd0;
        m_wb_valid = 1'b0;
        m_wb_da    = 5'd0;
        m_wb_data  = 64'd0;
    endtask

    task automatic model_op(input logic [2:0] fs, input logic [4:0] sa, input logic [4:0] sb,
                            input logic [4:0] da, input logic m, input logic wr,
                            input logic sfl, input logic [63:0] k);
        logic [63:0] a, b, r;
        logic [3:0]  fl;
        a = (sa == 5'd31) ? 64'd0 : m_rf[sa];
        b = m ? k : ((sb == 5'd31) ? 64'd0 : m_rf[sb]);
        r = ref_alu(fs, a, b, fl);
        if (sfl) m_stat = fl;
        m_wb_valid = wr && (da != 5'd31);
        if (m_wb_valid) begin
            m_wb_da   = da;
            m_wb_data = r;
            m_rf[da]  = r;
        end
    endtask

    task automatic drive(input logic [2:0] fs, input logic [4:0] sa, input logic [4:0] sb,
                         input logic [4:0] da, input logic m, input logic wr, input logic sfl,
                         input logic ld, input logic st, input logic [63:0] k);
        bus.in_valid = 1'b1;
        bus.fs = fs; bus.sa = sa; bus.sb = sb; bus.da = da;
        bus.m = m; bus.wr = wr; bus.sfl = sfl; bus.ld = ld; bus.st = st; bus.k = k;
    endtask

    task automatic idle_in();
        bus.in_valid = 1'b0;
        bus.ld = 1'b0;
        bus.st = 1'b0;
        bus.wr = 1'b0;
        bus.sfl = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        return (r >= 8) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0h exp=1", bus.in_ready); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got=%0h exp=0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 64'd0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 64'd0) begin errors++; $display("FAIL rst_mem_wdata got=%h exp=0", bus.mem_wdata); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got=%0h exp=0", bus.wb_valid); end
        checks++; if (bus.wb_data !== 64'd0) begin errors++; $display("FAIL rst_wb_data got=%h exp=0", bus.wb_data); end
        checks++; if (bus.stat !== 4'd0) begin errors++; $display("FAIL rst_stat got=%b exp=0000", bus.stat); end
        for (int i = 0; i < 4; i++) begin
            bus.dbg_sel = 5'(i);
            #1;
            checks++; if (bus.dbg_data !== 64'd0) begin errors++; $display("FAIL rst_rf%0d got=%h exp=0", i, bus.dbg_data); end
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_forward_sub();
        drive(3'd0, 5'd31, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd5);
        model_op(3'd0, 5'd31, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 64'd5);
        @(posedge clk); #1;
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_da !== 5'd1 || bus.wb_data !== 64'd5) begin
            errors++; $display("FAIL r1_wb got=%0h/%0d/%h exp=1/1/5", bus.wb_valid, bus.wb_da, bus.wb_data); end
        drive(3'd1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd5);
        model_op(3'd1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b1, 64'd5);
        @(posedge clk); #1;
        idle_in();
        checks++; if (bus.wb_data !== 64'd0) begin errors++; $display("FAIL sub_fwd_data got=%h exp=0", bus.wb_data); end
        checks++; if (bus.stat !== 4'b0110) begin errors++; $display("FAIL sub_stat got=%b exp=0110", bus.stat); end
        bus.dbg_sel = 5'd1;
        #1;
        checks++; if (bus.dbg_data !== 64'd5) begin errors++; $display("FAIL r1_file got=%h exp=5", bus.dbg_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        drive(3'd0, 5'd31, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
        model_op(3'd0, 5'd31, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        drive(3'd0, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd1);
        model_op(3'd0, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b1, 64'd1);
        @(posedge clk); #1;
        idle_in();
        checks++; if (bus.wb_data !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_data got=%h exp=8000000000000000", bus.wb_data); end
        checks++; if (bus.stat !== 4'b1001) begin errors++; $display("FAIL ovf_stat got=%b exp=1001", bus.stat); end
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        int low_cycles;
        low_cycles = 0;
        drive(3'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h10);
        @(posedge clk); #1;
        idle_in();
        for (int i = 0; i < 4; i++) begin
            if (bus.in_ready === 1'b0) low_cycles++;
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 64'h10 || bus.mem_we !== 1'b0) begin
                errors++; $display("FAIL ld_mem_stable cyc=%0d got=%0h/%h/%0h exp=1/10/0", i, bus.mem_req, bus.mem_addr, bus.mem_we); end
            if (i == 3) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 64'hABCD;
            end else begin
                bus.mem_rdata = {$urandom, $urandom};
            end
            @(posedge clk); #1;
        end
        bus.mem_ack = 1'b0;
        checks++; if (low_cycles != 4) begin errors++; $display("FAIL ld_ready_low got=%0d exp=4", low_cycles); end
        checks++; if (bus.in_ready !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL ld_done got=%0h/%0h exp=1/0", bus.in_ready, bus.mem_req); end
        checks++; if (bus.wb_valid !== 1'b1 || bus.wb_da !== 5'd3 || bus.wb_data !== 64'hABCD) begin
            errors++; $display("FAIL ld_wb got=%0h/%0d/%h exp=1/3/abcd", bus.wb_valid, bus.wb_da, bus.wb_data); end
        @(posedge clk); #1;
        bus.dbg_sel = 5'd3;
        #1;
        checks++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 64'hABCD) begin errors++; $display("FAIL ld_wb_pulse got=%0h/%h exp=0/abcd", bus.wb_valid, bus.wb_data); end
        checks++; if (bus.dbg_data !== 64'hABCD) begin errors++; $display("FAIL ld_r3 got=%h exp=abcd", bus.dbg_data); end
        m_rf[3] = 64'hABCD;
        m_wb_da = 5'd3;
        m_wb_data = 64'hABCD;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        drive(3'd0, 5'd31, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h55);
        model_op(3'd0, 5'd31, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 64'h55);
        @(posedge clk); #1;
        // store right behind the R4 write: data comes through forwarding
        drive(3'd0, 5'd31, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'd8);
        @(posedge clk); #1;
        idle_in();
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL st_req_we got=%0h/%0h exp=1/1", bus.mem_req, bus.mem_we); end
        checks++; if (bus.mem_wdata !== 64'h55) begin errors++; $display("FAIL st_wdata got=%h exp=55", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 64'd8) begin errors++; $display("FAIL st_addr got=%h exp=8", bus.mem_addr); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL st_wb_e got=%0h exp=0", bus.wb_valid); end
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL st_done got=%0h/%0h/%0h exp=0/1/0", bus.wb_valid, bus.in_ready, bus.mem_req); end
        @(posedge clk); #1;
        bus.dbg_sel = 5'd6;
        #1;
        checks++; if (bus.wb_valid !== 1'b0 || bus.dbg_data !== 64'd0) begin errors++; $display("FAIL st_no_wb got=%0h/%h exp=0/0", bus.wb_valid, bus.dbg_data); end
        // ack while idle must do nothing
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.mem_req !== 1'b0 || bus.wb_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ack got=%0h/%0h/%0h exp=1/0/0", bus.in_ready, bus.mem_req, bus.wb_valid); end
    endtask

    task automatic test_xzr();
        drive(3'd0, 5'd31, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd7);
        model_op(3'd0, 5'd31, 5'd0, 5'd31, 1'b1, 1'b1, 1'b0, 64'd7);
        @(posedge clk); #1;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL xzr_wb got=%0h exp=0", bus.wb_valid); end
        drive(3'd0, 5'd31, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'd0);
        model_op(3'd0, 5'd31, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 64'd0);
        @(posedge clk); #1;
        checks++; if (bus.wb_data !== 64'd0 || bus.stat !== 4'b0100) begin errors++; $display("FAIL xzr_opa got=%h/%b exp=0/0100", bus.wb_data, bus.stat); end
        drive(3'd3, 5'd1, 5'd31, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF);
        model_op(3'd3, 5'd1, 5'd31, 5'd6, 1'b0, 1'b1, 1'b0, 64'hFFFF);
        @(posedge clk); #1;
        idle_in();
        checks++; if (bus.wb_data !== 64'd5) begin errors++; $display("FAIL xzr_opb got=%h exp=5", bus.wb_data); end
        bus.dbg_sel = 5'd31;
        #1;
        checks++; if (bus.dbg_data !== 64'd0) begin errors++; $display("FAIL xzr_dbg got=%h exp=0", bus.dbg_data); end
        @(posedge clk); #1;
        m_wb_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  fs;
        logic [4:0]  sa, sb, da;
        logic        m, wr, sfl;
        logic [63:0] k;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle_in();
                m_wb_valid = 1'b0;
            end else begin
                fs = 3'($urandom_range(0, 7));
                sa = pick_reg(); sb = pick_reg(); da = pick_reg();
                m = 1'($urandom_range(0, 1));
                wr = ($urandom_range(0, 3) != 0);
                sfl = 1'($urandom_range(0, 1));
                k = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
                drive(fs, sa, sb, da, m, wr, sfl, 1'b0, 1'b0, k);
                model_op(fs, sa, sb, da, m, wr, sfl, k);
            end
            @(posedge clk); #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready it=%0d got=%0h exp=1", i, bus.in_ready); end
            checks++; if (bus.wb_valid !== m_wb_valid) begin errors++; $display("FAIL b2b_wb_valid it=%0d got=%0h exp=%0h", i, bus.wb_valid, m_wb_valid); end
            checks++; if (bus.wb_da !== m_wb_da || bus.wb_data !== m_wb_data) begin
                errors++; $display("FAIL b2b_wb it=%0d got=%0d/%h exp=%0d/%h", i, bus.wb_da, bus.wb_data, m_wb_da, m_wb_data); end
            checks++; if (bus.stat !== m_stat) begin errors++; $display("FAIL b2b_stat it=%0d got=%b exp=%b", i, bus.stat, m_stat); end
        end
        idle_in();
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            bus.dbg_sel = 5'(i);
            #1;
            checks++; if (bus.dbg_data !== ((i == 31) ? 64'd0 : m_rf[i])) begin
                errors++; $display("FAIL b2b_rf%0d got=%h exp=%h", i, bus.dbg_data, (i == 31) ? 64'd0 : m_rf[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_mem();
        drive(3'd0, 5'd31, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 64'h20);
        @(posedge clk); #1;
        idle_in();
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rim_req1 got=%0h exp=1", bus.mem_req); end
        @(posedge clk); #1;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rim_async got=%0h/%0h exp=0/1", bus.mem_req, bus.in_ready); end
        checks++; if (bus.mem_addr !== 64'd0 || bus.mem_we !== 1'b0 || bus.stat !== 4'd0) begin
            errors++; $display("FAIL rim_clear got=%h/%0h/%b exp=0/0/0000", bus.mem_addr, bus.mem_we, bus.stat); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 64'h1234;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL rim_ack got=%0h/%0h/%0h exp=0/1/0", bus.wb_valid, bus.in_ready, bus.mem_req); end
        @(posedge clk); #1;
        bus.dbg_sel = 5'd7;
        #1;
        checks++; if (bus.wb_valid !== 1'b0 || bus.dbg_data !== 64'd0) begin errors++; $display("FAIL rim_no_wb got=%0h/%h exp=0/0", bus.wb_valid, bus.dbg_data); end
        bus.dbg_sel = 5'd3;
        #1;
        checks++; if (bus.dbg_data !== 64'd0) begin errors++; $display("FAIL rim_rf_clear got=%h exp=0", bus.dbg_data); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.in_valid = 1'b0; bus.sa = '0; bus.sb = '0; bus.da = '0;
        bus.wr = 1'b0; bus.sfl = 1'b0; bus.m = 1'b0; bus.fs = '0; bus.k = '0;
        bus.ld = 1'b0; bus.st = 1'b0; bus.mem_rdata = '0; bus.mem_ack = 1'b0; bus.dbg_sel = '0;
        test_reset();
        test_forward_sub();
        test_overflow();
        test_load();
        test_store();
        test_xzr();
        test_back_to_back();
        test_reset_in_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_datapath.md
PIPE_DATAPATH -- requirements
Module: pipe_datapath

Interface
REQ-001 Parameter DW, 64, data width of registers, ALU, K and memory data/address.
REQ-002 Parameter NREG, 32, number of registers in the internal file.
REQ-003 Parameter AW, 5, register select width, equal to log2(NREG).
REQ-004 Port CLK input 1: single clock; all state updates on rising edge.
REQ-005 Port RST input 1: asynchronous, active-high reset.
REQ-006 Ports IN_VALID input 1 and IN_READY output 1: issue handshake; an operation is accepted when both are high at a rising edge.
REQ-007 Ports SA, SB, DA input AW each: A-operand, B-operand and destination selects.
REQ-008 Ports WR input 1, SFL input 1, M input 1: write-enable, store-flags, B/K select (1 selects K).
REQ-009 Ports FS input 3 and K input DW: ALU function and constant.
REQ-010 Ports LD input 1 and ST input 1: load and store; both high is treated as LD.
REQ-011 Ports MEM_REQ, MEM_WE output 1 each; MEM_ADDR and MEM_WDATA output DW each; MEM_RDATA input DW; MEM_ACK input 1.
REQ-012 Ports WB_VALID output 1, WB_DA output AW, WB_DATA output DW: writeback stage contents.
REQ-013 Port STAT output 4: registered flags {N,Z,C,V}.
REQ-014 Ports DBG_SEL input AW and DBG_DATA output DW: combinational read of the selected register file entry, with no forwarding.

Function
REQ-015 Register NREG-1 reads as zero; writes to it are discarded, and no writeback or forward occurs for it.
REQ-016 ALU operand A is reg[SA]; operand B is K when M=1, else reg[SB].
REQ-017 FS encoding: 0 ADD, 1 SUB (A+~B+1), 2 AND, 3 OR, 4 XOR, 5 PASSB, 6 LSL A by B[log2(DW)-1:0], 7 LSR by the same amount.
REQ-018 Flags: N = result MSB; Z = (result==0). For ADD/SUB, C = carry-out and V = signed overflow. For all other functions, C = V = 0.
REQ-019 STAT updates at the accept edge only when SFL=1; otherwise it holds.
REQ-020 Stage E (read+execute) is the cycle of acceptance; stage W is the register loaded at the accept edge.
REQ-021 WB_VALID=1 during the cycle after acceptance when WR=1 and LD=ST=0; reg[WB_DA] is written at the end of that cycle.
REQ-022 Forwarding: if WB_VALID=1 and WB_DA equals SA or SB (and is not NREG-1), the E-stage operand uses WB_DATA instead of the file value.
REQ-023 Controller states are IDLE and MEM; IN_READY = (state==IDLE).
REQ-024 Accepting LD or ST moves IDLE to MEM; MEM returns to IDLE at the first edge with MEM_ACK=1.
REQ-025 In MEM: MEM_REQ=1, MEM_ADDR = the registered ALU result, MEM_WE = ST, and MEM_WDATA = the registered (forwarded) B-register value. All four are held stable until MEM_ACK.
REQ-026 MEM_ACK is ignored in IDLE.
REQ-027 LD with WR=1: WB_DATA captures MEM_RDATA at the ack edge; WB_VALID=1 in the following cycle.
REQ-028 LD with WR=0 and ST complete with no writeback.
REQ-029 Minimum LD/ST occupancy is 2 cycles: accept, then at least one MEM cycle.
REQ-030 WB_VALID is a one-cycle pulse per writing operation. WB_DA and WB_DATA hold their last values when WB_VALID=0.
REQ-031 Back-to-back non-memory operations sustain one per cycle with no bubbles.

Reset
REQ-032 RST=1 immediately clears all registers, STAT, the W stage and WB_*; the state returns to IDLE.
REQ-033 During reset: MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, IN_READY=1.
REQ-034 Reset during MEM abandons the access; a later MEM_ACK is ignored and no writeback occurs.

Verification
REQ-035 Reset, then R1=5 via ADD XZR+K(5), then SUB R2=R1-K(5) with SFL -> WB_DATA=0, STAT=0110 (Z, C set), with forwarding of R1.
REQ-036 ADD with A=0x7FFF_FFFF_FFFF_FFFF and K=1, SFL=1 -> result 0x8000_0000_0000_0000, STAT=1001.
REQ-037 LD R3 at address R0+K(0x10) with MEM_ACK delayed 3 cycles, MEM_RDATA=0xABCD -> IN_READY low 4 cycles, MEM signals stable, then WB_DATA=0xABCD and R3=0xABCD.
REQ-038 ST R4 (=0x55) at address 8 -> MEM_WE=1, MEM_WDATA=0x55, MEM_ADDR=8, no WB_VALID pulse.
REQ-039 Write to register NREG-1 with K=7, then read it via DBG_SEL and as an operand -> value 0, no forward.
REQ-040 Assert RST in the second MEM cycle, then pulse MEM_ACK -> MEM_REQ drops at once, no writeback occurs, and IN_READY=1.
